nf_reg_file_wr_arb: RTL
=======================

Name: nf_reg_file_wr_arb

Overview:
- Controller for the write port (wa3/wd3/we3) of the 32x32 register file.
- Three jobs:
  - After reset, sequences a clear of all registers to zero.
  - Shares the single write port between core writeback and a debug/loader write requester.
  - Suppresses writes to register x0.
- Sits between the core writeback stage, the debug interface and the register file.

Parameters:
- NUM_REGS, 32, number of registers cleared and addressable.
- ADDR_W, 5, register address width (log2 NUM_REGS).
- DATA_W, 32, register data width.
- STARVE_LIM, 8, consecutive cycles a pending debug request may lose to writeback before it is forced through (range 1..255).

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- wb_we  input  1  core writeback write enable.
- wb_wa  input  ADDR_W  core writeback address.
- wb_wd  input  DATA_W  core writeback data.
- wb_stall  output  1  core must freeze and hold its writeback request.
- dbg_req  input  1  debug write request; held until ack.
- dbg_wa  input  ADDR_W  debug write address; stable while dbg_req=1.
- dbg_wd  input  DATA_W  debug write data; stable while dbg_req=1.
- dbg_ack  output  1  single-cycle pulse; debug write accepted this cycle.
- init_done  output  1  high once clear sequence has finished.
- rf_we3  output  1  to register file we3.
- rf_wa3  output  ADDR_W  to register file wa3.
- rf_wd3  output  DATA_W  to register file wd3.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Outputs are combinational decodes of registered state plus current inputs.
- While rst=1: rf_we3=0, rf_wa3=0, rf_wd3=0, dbg_ack=0, init_done=0, wb_stall=1. State goes to CLEAR, clear counter=0, starve counter=0.
- State CLEAR:
  - rf_we3=1, rf_wa3=clear counter, rf_wd3=0, wb_stall=1, dbg_ack=0.
  - The counter increments every cycle.
  - After address NUM_REGS-1 is written, go to RUN. The clear therefore takes exactly NUM_REGS cycles after rst falls.
  - x0 is written (with zero) during CLEAR only.
  - Asserting rst mid-clear restarts the clear from address 0.
- State RUN:
  - init_done=1.
  - Priority 1: if wb_we=1 and wb_wa!=0, drive wb_wa/wb_wd with rf_we3=1 and wb_stall=0. A pending dbg_req is not acked; the starve counter increments.
  - Priority 2: else if dbg_req=1, dbg_ack=1 and the starve counter clears. rf_we3=1 only if dbg_wa!=0; dbg_wa=0 is acked as a no-op.
  - wb_we=1 with wb_wa=0 is a no-op and does not block debug.
  - With no request, rf_we3=0.
  - When the starve counter reaches STARVE_LIM-1 and another loss occurs, go to FORCE next cycle.
- State FORCE (1 cycle):
  - wb_stall=1, debug write driven, dbg_ack=1, starve counter cleared, return to RUN.
  - The core holds wb_we/wb_wa/wb_wd unchanged and writes in the following RUN cycle.
- dbg_req dropping before ack clears the starve counter.
- Debug requester must deassert dbg_req the cycle after dbg_ack, or it is treated as a new request.
- Write-port latency: zero. The register file captures on the same clk edge the request is granted.

Optional Feature:
- Macro: NF_RF_CLEAR_EN.
- Defined: CLEAR sequence as above.
- Undefined: no clear counter. Reset leaves the state in RUN, with init_done=0 and wb_stall=1 only while rst=1, and init_done=1 from the first cycle after rst falls. Register contents are undefined until written.

Decomposition:
- Shared package nf_rf_pkg holds:
  - state enum typedef (CLEAR, RUN, FORCE);
  - NF_RF_ADDR_W and NF_RF_DATA_W constants;
  - STARVE_LIM default constant.
- One natural sub-module: nf_rf_starve_cnt, a saturating counter with inc/clr/hit outputs.
- Remaining logic stays flat in nf_reg_file_wr_arb.

Test Plan:
- Clear: pulse rst 2 cycles, release. Required: rf_we3=1 with rf_wa3=0..31 and rf_wd3=0 over 32 cycles, wb_stall=1 throughout, then init_done=1 and wb_stall=0 on cycle 33.
- Priority: same cycle wb_we=1, wb_wa=5, wb_wd=0xAAAA_0001, and dbg_req=1, dbg_wa=6, dbg_wd=0x1234. Required: rf_wa3=5, dbg_ack=0. Next cycle wb_we=0, so rf_wa3=6, rf_wd3=0x1234, dbg_ack=1.
- x0 suppression: wb_we=1, wb_wa=0 together with dbg_req=1, dbg_wa=0. Required: rf_we3=0, dbg_ack=1.
- Starvation (STARVE_LIM=8): wb_we=1, wb_wa=3 every cycle with dbg_req=1, dbg_wa=7. Required: 8 writeback grants, then one cycle with wb_stall=1, rf_wa3=7, dbg_ack=1. The held writeback to 3 completes the next cycle.
- Reset mid-clear: assert rst at clear address 12 for 1 cycle. Required: clear restarts at address 0 and init_done rises 32 cycles after rst falls.
- Build with NF_RF_CLEAR_EN undefined. Required: init_done=1 the first cycle after rst falls, and a wb write is accepted that cycle.

Source files
------------

// File: rtl/nf_rf_pkg.sv
// Shared types and default sizes for the register-file write-port arbiter.
package nf_rf_pkg;

  localparam int NF_RF_NUM_REGS   = 32;
  localparam int NF_RF_ADDR_W     = 5;
  localparam int NF_RF_DATA_W     = 32;
  localparam int NF_RF_STARVE_LIM = 8;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_FORCE = 2'd2
  } nf_rf_state_e;

endpackage

// File: rtl/nf_rf_starve_cnt.sv
// Saturating count of consecutive cycles a pending debug write lost the port.
// hit is high once the count sits at LIM-1, so the next loss forces debug through.
module nf_rf_starve_cnt #(
  parameter int LIM = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [7:0] TOP = 8'(LIM - 1);

  logic [7:0] cnt;

  // Count losses, holding at TOP; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != TOP)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign hit = (cnt == TOP);

endmodule

// File: rtl/nf_reg_file_wr_arb.sv
// Write-port controller for the 32x32 register file: post-reset clear,
// writeback/debug sharing with starvation guard, and x0 write suppression.
// Optional feature macro: NF_RF_CLEAR_EN (defined = clear all registers after reset).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | writing zero to every register, core and debug held off
// ST_RUN   | writeback has priority, debug takes idle cycles
// ST_FORCE | one cycle: core stalled, starved debug write goes through
module nf_reg_file_wr_arb
  import nf_rf_pkg::*;
#(
  parameter int NUM_REGS   = NF_RF_NUM_REGS,
  parameter int ADDR_W     = NF_RF_ADDR_W,
  parameter int DATA_W     = NF_RF_DATA_W,
  parameter int STARVE_LIM = NF_RF_STARVE_LIM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  output logic              wb_stall,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_wa,
  input  logic [DATA_W-1:0] dbg_wd,
  output logic              dbg_ack,
  output logic              init_done,
  output logic              rf_we3,
  output logic [ADDR_W-1:0] rf_wa3,
  output logic [DATA_W-1:0] rf_wd3
);

  localparam logic [ADDR_W:0] REG_COUNT = (ADDR_W + 1)'(NUM_REGS);

  nf_rf_state_e state_q, state_d;
  logic         cnt_inc, cnt_clr, starve_hit;
  logic         wb_ok, dbg_ok;

  // x0 is hard-wired zero, and addresses past the last register are dropped.
  assign wb_ok  = wb_we && (wb_wa != '0) && ({1'b0, wb_wa} < REG_COUNT);
  assign dbg_ok = (dbg_wa != '0) && ({1'b0, dbg_wa} < REG_COUNT);

`ifdef NF_RF_CLEAR_EN
  localparam nf_rf_state_e RST_STATE = ST_CLEAR;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [ADDR_W-1:0] clr_cnt;

  // Clear address walks up one register per cycle while clearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end
  end
`else
  localparam nf_rf_state_e RST_STATE = ST_RUN;
`endif

  nf_rf_starve_cnt #(
    .LIM (STARVE_LIM)
  ) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (cnt_clr),
    .hit (starve_hit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and port grant; reset overrides every output.
  always_comb begin
    state_d   = state_q;
    rf_we3    = 1'b0;
    rf_wa3    = '0;
    rf_wd3    = '0;
    dbg_ack   = 1'b0;
    wb_stall  = 1'b0;
    init_done = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;

    case (state_q)
`ifdef NF_RF_CLEAR_EN
      ST_CLEAR: begin
        rf_we3   = 1'b1;
        rf_wa3   = clr_cnt;
        wb_stall = 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
`endif
      ST_RUN: begin
        init_done = 1'b1;
        if (wb_ok) begin
          rf_we3 = 1'b1;
          rf_wa3 = wb_wa;
          rf_wd3 = wb_wd;
          if (dbg_req) begin
            cnt_inc = 1'b1;
            if (starve_hit) begin
              state_d = ST_FORCE;
            end
          end
        end else if (dbg_req) begin
          dbg_ack = 1'b1;
          cnt_clr = 1'b1;
          rf_we3  = dbg_ok;
          rf_wa3  = dbg_wa;
          rf_wd3  = dbg_wd;
        end
        if (!dbg_req) begin
          cnt_clr = 1'b1;
        end
      end
      ST_FORCE: begin
        init_done = 1'b1;
        wb_stall  = 1'b1;
        dbg_ack   = dbg_req;
        rf_we3    = dbg_req && dbg_ok;
        rf_wa3    = dbg_wa;
        rf_wd3    = dbg_wd;
        cnt_clr   = 1'b1;
        state_d   = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (rst) begin
      rf_we3    = 1'b0;
      rf_wa3    = '0;
      rf_wd3    = '0;
      dbg_ack   = 1'b0;
      wb_stall  = 1'b1;
      init_done = 1'b0;
    end
  end

endmodule
